// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction-fetch / data memory port arbiter.
package mem_arb_pkg;

    localparam int DefWidth    = 32;
    localparam int BeWidth     = 4;
    localparam int StreakWidth = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_streak_cnt.sv
// Counts consecutive data-port wins while a fetch is waiting. It saturates at
// MaxStreak, and sat_o tells the arbiter to let the fetch through next.
module arb_streak_cnt
    import mem_arb_pkg::*;
#(
    parameter int MaxStreak = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [StreakWidth-1:0] SatVal = StreakWidth'(MaxStreak);

    logic [StreakWidth-1:0] cnt_q;
    logic [StreakWidth-1:0] cnt_d;

    // Next count: clear has priority, and increment stops at the saturation value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != SatVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == SatVal);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port. Only one
// transaction is outstanding at a time. Data has priority, but a starvation
// streak limit guarantees that a waiting fetch is eventually served.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int Width     = DefWidth,
    parameter int MaxStreak = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    // fetch port
    input  logic               if_req_i,
    input  logic [Width-1:0]   if_addr_i,
    output logic               if_gnt_o,
    output logic               if_rvalid_o,
    output logic [Width-1:0]   if_rdata_o,
    input  logic               flush_i,
    // data port
    input  logic               d_req_i,
    input  logic               d_we_i,
    input  logic [BeWidth-1:0] d_be_i,
    input  logic [Width-1:0]   d_addr_i,
    input  logic [Width-1:0]   d_wdata_i,
    output logic               d_gnt_o,
    output logic               d_rvalid_o,
    output logic [Width-1:0]   d_rdata_o,
    // shared memory port
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [BeWidth-1:0] mem_be_o,
    output logic [Width-1:0]   mem_addr_o,
    output logic [Width-1:0]   mem_wdata_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [Width-1:0]   mem_rdata_i
);

    arb_state_e         state_q, state_d;
    owner_e             owner_q, owner_d;
    logic               drop_q, drop_d;
    logic               we_q, we_d;
    logic [BeWidth-1:0] be_q, be_d;
    logic [Width-1:0]   addr_q, addr_d;
    logic [Width-1:0]   wdata_q, wdata_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic [Width-1:0]   if_rdata_q, if_rdata_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic [Width-1:0]   d_rdata_q, d_rdata_d;

    logic if_eff;
    logic if_wins;
    logic arb_go;
    logic streak_inc;
    logic streak_clr;
    logic streak_sat;
    logic drop_now;
    logic rsp_done;

    // A redirect in the same cycle makes the fetch request stale, so it does not compete.
    assign if_eff  = if_req_i & ~flush_i;
    assign if_wins = if_eff & (~d_req_i | streak_sat);
    assign arb_go  = (state_q == IDLE) & (if_eff | d_req_i);

    // The streak grows only when a data win makes a live fetch wait.
    assign streak_inc = arb_go & ~if_wins & if_eff;
    assign streak_clr = arb_go & (if_wins | ~if_eff);

    // A fetch in flight is orphaned by a redirect that arrives this cycle or earlier.
    assign drop_now = drop_q | (flush_i & (owner_q == OWN_IF));

    arb_streak_cnt #(
        .MaxStreak (MaxStreak)
    ) u_streak (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (streak_inc),
        .clr_i (streak_clr),
        .sat_o (streak_sat)
    );

    // FSM next state, payload latch and memory/grant outputs.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_d      = drop_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_done    = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_go) begin
                    state_d = REQ;
                    if (if_wins) begin
                        owner_d = OWN_IF;
                        we_d    = 1'b0;
                        be_d    = {BeWidth{1'b1}};
                        addr_d  = if_addr_i;
                        wdata_d = '0;
                    end else begin
                        owner_d = OWN_D;
                        we_d    = d_we_i;
                        be_d    = d_be_i;
                        addr_d  = d_addr_i;
                        wdata_d = d_wdata_i;
                    end
                end
            end
            REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_be_o    = be_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                drop_d      = drop_now;
                if (mem_gnt_i) begin
                    if (owner_q == OWN_IF) begin
                        if_gnt_o = ~drop_now;
                    end else begin
                        d_gnt_o = 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        rsp_done = 1'b1;
                        state_d  = IDLE;
                        drop_d   = 1'b0;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                drop_d = drop_now;
                if (mem_rvalid_i) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                    drop_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Route a completed response to its owner; dropped fetches leave rdata untouched.
    always_comb begin
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if (rsp_done) begin
            if (owner_q == OWN_D) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = mem_rdata_i;
            end else if (!drop_now) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = mem_rdata_i;
            end
        end
    end

    // State, payload and response registers; reset abandons any transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_D;
            drop_q      <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drop_q      <= drop_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for streak fairness, flush and reset corner cases.
module tb_mem_port_arbiter;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         if_req_i;
    logic [W-1:0] if_addr_i;
    logic         if_gnt_o;
    logic         if_rvalid_o;
    logic [W-1:0] if_rdata_o;
    logic         flush_i;
    logic         d_req_i;
    logic         d_we_i;
    logic [3:0]   d_be_i;
    logic [W-1:0] d_addr_i;
    logic [W-1:0] d_wdata_i;
    logic         d_gnt_o;
    logic         d_rvalid_o;
    logic [W-1:0] d_rdata_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [3:0]   mem_be_o;
    logic [W-1:0] mem_addr_o;
    logic [W-1:0] mem_wdata_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [W-1:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .Width     (W),
        .MaxStreak (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .flush_i      (flush_i),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_be_i       (d_be_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_gnt_o      (d_gnt_o),
        .d_rvalid_o   (d_rvalid_o),
        .d_rdata_o    (d_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        use_if;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rsp_dly;
        logic [31:0] rdata;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        flush_i      = 1'b0;
        d_req_i      = 1'b0;
        d_we_i       = 1'b0;
        d_be_i       = '0;
        d_addr_i     = '0;
        d_wdata_i    = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_req"},   mem_req_o,   0);
        chk({tag, "_mem_we"},    mem_we_o,    0);
        chk({tag, "_mem_be"},    mem_be_o,    0);
        chk({tag, "_mem_addr"},  mem_addr_o,  0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
        chk({tag, "_if_gnt"},    if_gnt_o,    0);
        chk({tag, "_d_gnt"},     d_gnt_o,     0);
        chk({tag, "_if_rvalid"}, if_rvalid_o, 0);
        chk({tag, "_d_rvalid"},  d_rvalid_o,  0);
        chk({tag, "_if_rdata"},  if_rdata_o,  0);
        chk({tag, "_d_rdata"},   d_rdata_o,   0);
    endtask

    // One table transaction: request, latched payload on mem_*, owner grant, response pulse.
    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        clear_inputs();
        if (v.use_if) begin
            if_req_i  = 1'b1;
            if_addr_i = v.addr;
        end else begin
            d_req_i   = 1'b1;
            d_we_i    = v.we;
            d_be_i    = v.be;
            d_addr_i  = v.addr;
            d_wdata_i = v.wdata;
        end
        #1;
        chk($sformatf("v%0d_idle_mem_req", idx), mem_req_o, 0);
        tick();
        for (int k = 0; k <= v.gnt_dly; k++) begin
            mem_gnt_i    = (k == v.gnt_dly);
            mem_rvalid_i = (k == v.gnt_dly) && (v.rsp_dly == 0);
            mem_rdata_i  = v.rdata;
            if (k > 0) begin
                if_addr_i = ~v.addr;
                d_addr_i  = ~v.addr;
                d_be_i    = ~v.be;
                d_we_i    = ~v.we;
                d_wdata_i = ~v.wdata;
            end
            #1;
            chk($sformatf("v%0d_c%0d_mem_req", idx, k),  mem_req_o,  1);
            chk($sformatf("v%0d_c%0d_mem_addr", idx, k), mem_addr_o, v.addr);
            chk($sformatf("v%0d_c%0d_mem_we", idx, k),   mem_we_o,   v.exp_we);
            chk($sformatf("v%0d_c%0d_mem_be", idx, k),   mem_be_o,   v.exp_be);
            if (v.exp_we)
                chk($sformatf("v%0d_c%0d_mem_wdata", idx, k), mem_wdata_o, v.wdata);
            chk($sformatf("v%0d_c%0d_owner_gnt", idx, k),
                v.use_if ? if_gnt_o : d_gnt_o, (k == v.gnt_dly));
            chk($sformatf("v%0d_c%0d_other_gnt", idx, k),
                v.use_if ? d_gnt_o : if_gnt_o, 0);
            tick();
        end
        clear_inputs();
        for (int r = 1; r <= v.rsp_dly; r++) begin
            mem_rvalid_i = (r == v.rsp_dly);
            mem_rdata_i  = (r == v.rsp_dly) ? v.rdata : 32'hFFFF_FFFF;
            #1;
            chk($sformatf("v%0d_w%0d_mem_req", idx, r), mem_req_o, 0);
            chk($sformatf("v%0d_w%0d_rvalids", idx, r), {if_rvalid_o, d_rvalid_o}, 0);
            tick();
        end
        clear_inputs();
        #1;
        chk($sformatf("v%0d_owner_rvalid", idx), v.use_if ? if_rvalid_o : d_rvalid_o, 1);
        chk($sformatf("v%0d_other_rvalid", idx), v.use_if ? d_rvalid_o : if_rvalid_o, 0);
        if (v.chk_rdata)
            chk($sformatf("v%0d_owner_rdata", idx), v.use_if ? if_rdata_o : d_rdata_o, v.exp_rdata);
        tick();
        chk($sformatf("v%0d_rvalid_pulse_end", idx), v.use_if ? if_rvalid_o : d_rvalid_o, 0);
        if (v.chk_rdata)
            chk($sformatf("v%0d_rdata_hold", idx), v.use_if ? if_rdata_o : d_rdata_o, v.exp_rdata);
        $display("txn %0d: %s addr=0x%0h gnt_dly=%0d rsp_dly=%0d errors so far=%0d",
                 idx, v.use_if ? "fetch" : (v.we ? "store" : "load"), v.addr,
                 v.gnt_dly, v.rsp_dly, errors);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_is_d [10];
        int   n_gnt;

        //            use_if we    be     addr          wdata         gd rd rdata         exp_we exp_be chk   exp_rdata
        vecs[0] = '{1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0,        0, 1, 32'h0000_0013, 1'b0, 4'hF, 1'b1, 32'h0000_0013};
        vecs[1] = '{1'b0, 1'b1, 4'h3, 32'h0000_07F0, 32'h0000_ABCD, 3, 1, 32'h0,        1'b1, 4'h3, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'h0,        0, 0, 32'h0000_0055, 1'b0, 4'hF, 1'b1, 32'h0000_0055};
        vecs[3] = '{1'b0, 1'b0, 4'hC, 32'h0000_0044, 32'h0,        1, 2, 32'hCAFE_F00D, 1'b0, 4'hC, 1'b1, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b0, 4'h0, 32'h0000_0104, 32'h0,        2, 0, 32'h0010_0093, 1'b0, 4'hF, 1'b1, 32'h0010_0093};
        exp_is_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // reset state
        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check_all_zero("reset");

        for (int i = 0; i < 5; i++) run_vec(i);

        // streak fairness: both ports request continuously, memory answers at once
        tick();
        clear_inputs();
        if_req_i     = 1'b1;
        if_addr_i    = 32'h300;
        d_req_i      = 1'b1;
        d_be_i       = 4'hF;
        d_addr_i     = 32'h400;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_1111;
        n_gnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (if_gnt_o && d_gnt_o) chk("streak_double_gnt", 1, 0);
            if (if_gnt_o || d_gnt_o) begin
                chk($sformatf("streak_grant_%0d_is_data", n_gnt), d_gnt_o, exp_is_d[n_gnt]);
                n_gnt++;
            end
            if (n_gnt == 10) break;
            tick();
        end
        chk("streak_grant_count", n_gnt, 10);
        tick();
        clear_inputs();
        tick();
        tick();
        $display("txn streak: %0d grants observed, errors so far=%0d", n_gnt, errors);

        // flush in IDLE hides the fetch for that cycle only
        if_req_i  = 1'b1;
        if_addr_i = 32'h200;
        flush_i   = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        chk("flush_idle_no_req", mem_req_o, 0);
        tick();
        mem_gnt_i = 1'b1;
        #1;
        chk("flushB_mem_addr", mem_addr_o, 32'h200);
        chk("flushB_if_gnt", if_gnt_o, 1);
        tick();
        // flush while waiting for the response
        clear_inputs();
        flush_i = 1'b1;
        #1;
        chk("flushB_wait_rvalid", if_rvalid_o, 0);
        tick();
        flush_i      = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        tick();
        clear_inputs();
        if_req_i  = 1'b1;
        if_addr_i = 32'h204;
        #1;
        chk("flushB_dropped_rvalid", if_rvalid_o, 0);
        chk("flushB_rdata_kept", if_rdata_o, 32'h0000_1111);
        tick();
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h77;
        #1;
        chk("flushB_next_mem_addr", mem_addr_o, 32'h204);
        chk("flushB_next_if_gnt", if_gnt_o, 1);
        tick();
        clear_inputs();
        #1;
        chk("flushB_next_rvalid", if_rvalid_o, 1);
        chk("flushB_next_rdata", if_rdata_o, 32'h77);
        $display("txn flush-wait: fetch 0x200 dropped, fetch 0x204 served, errors so far=%0d", errors);
        // flush while the fetch still waits for its grant
        if_req_i  = 1'b1;
        if_addr_i = 32'h208;
        tick();
        flush_i = 1'b1;
        #1;
        chk("flushR_mem_req", mem_req_o, 1);
        tick();
        clear_inputs();
        mem_gnt_i = 1'b1;
        #1;
        chk("flushR_mem_req_held", mem_req_o, 1);
        chk("flushR_if_gnt_suppressed", if_gnt_o, 0);
        tick();
        clear_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hEEEE;
        tick();
        clear_inputs();
        #1;
        chk("flushR_rvalid", if_rvalid_o, 0);
        chk("flushR_rdata_kept", if_rdata_o, 32'h77);
        // data transactions ignore flush
        d_req_i  = 1'b1;
        d_be_i   = 4'hF;
        d_addr_i = 32'h48;
        tick();
        mem_gnt_i = 1'b1;
        #1;
        chk("flushD_gnt", d_gnt_o, 1);
        tick();
        clear_inputs();
        flush_i      = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h4848;
        tick();
        clear_inputs();
        #1;
        chk("flushD_rvalid", d_rvalid_o, 1);
        chk("flushD_rdata", d_rdata_o, 32'h4848);
        tick();
        $display("txn flush-req: fetch 0x208 dropped, load 0x48 served, errors so far=%0d", errors);

        // reset in WAIT_RSP followed by a late response
        d_req_i  = 1'b1;
        d_be_i   = 4'hF;
        d_addr_i = 32'h80;
        tick();
        mem_gnt_i = 1'b1;
        #1;
        chk("rstW_d_gnt", d_gnt_o, 1);
        tick();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        rst_i        = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h99;
        #1;
        check_all_zero("rstW");
        tick();
        clear_inputs();
        d_req_i  = 1'b1;
        d_be_i   = 4'hF;
        d_addr_i = 32'h84;
        #1;
        chk("rstW_late_rvalid", d_rvalid_o, 0);
        chk("rstW_late_rdata", d_rdata_o, 0);
        tick();
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5A;
        #1;
        chk("rstW_after_mem_req", mem_req_o, 1);
        chk("rstW_after_mem_addr", mem_addr_o, 32'h84);
        tick();
        clear_inputs();
        #1;
        chk("rstW_after_rvalid", d_rvalid_o, 1);
        chk("rstW_after_rdata", d_rdata_o, 32'h5A);
        $display("txn reset-wait: late response ignored, load 0x84 served, errors so far=%0d", errors);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
